bilinear_scale_ctrl: RTL and testbench

Frame-level sequencer for the bilinear scaler datapath. On a start pulse it latches source/destination sizes and computes the fixed-point scale steps with a sequential divider. It then walks the destination raster, issuing one request per output pixel over a valid/ready handshake. Each request carries the four source-pixel coordinates and the four FIX_WIDTH weights consumed by the downstream fetch stage and the bilinear arithmetic stage.

---
 rtl/bilinear_scale_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_bilinear_scale_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bilinear_scale_ctrl.sv
// bilinear_scale_ctrl: frame sequencer for the bilinear scaler datapath.
// Latches sizes on start, derives fixed-point steps with two restoring
// dividers, then walks the destination raster issuing one valid/ready
// request per output pixel (4 source coords + 4 bilinear weights).
// Optional macro: BILINEAR_HALF_PIXEL_EN selects center-aligned mapping.
module bilinear_scale_ctrl #(
  parameter int FIX_WIDTH   = 12,
  parameter int COORD_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic [COORD_WIDTH-1:0] src_width_i,
  input  logic [COORD_WIDTH-1:0] src_height_i,
  input  logic [COORD_WIDTH-1:0] dest_width_i,
  input  logic [COORD_WIDTH-1:0] dest_height_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic [COORD_WIDTH-1:0] req_x0_o,
  output logic [COORD_WIDTH-1:0] req_x1_o,
  output logic [COORD_WIDTH-1:0] req_y0_o,
  output logic [COORD_WIDTH-1:0] req_y1_o,
  output logic [FIX_WIDTH-1:0]   weight00_o,
  output logic [FIX_WIDTH-1:0]   weight01_o,
  output logic [FIX_WIDTH-1:0]   weight10_o,
  output logic [FIX_WIDTH-1:0]   weight11_o,
  output logic                   req_sof_o,
  output logic                   req_eol_o
);
  localparam int FW         = FIX_WIDTH;
  localparam int CW         = COORD_WIDTH;
  localparam int QW         = CW + FW;      // quotient / step width
  localparam int AW         = CW + FW + 1;  // accumulator width
  localparam int DIV_CYCLES = QW;
  localparam int CNTW       = $clog2(DIV_CYCLES);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DIV_CYCLES - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CW-1:0]   ONE_CW   = CW'(1);
  localparam logic [FW:0]     UNITY    = {1'b1, {FW{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_DIV, S_LOAD, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic [CW-1:0] p0;
    logic [CW-1:0] p1;
    logic [FW:0]   w0;
    logic [FW:0]   w1;
  } axis_t;

  // Map an accumulator to the two neighbouring source positions and weights.
  // Beyond the last source sample both taps collapse onto the edge pixel.
  function automatic axis_t map_axis(input logic [AW-1:0] acc, input logic [CW-1:0] sz);
    axis_t          r;
    logic [CW:0]    ip;
    logic [CW:0]    lastc;
    logic [FW-1:0]  fr;
    ip    = acc[AW-1:FW];
    fr    = acc[FW-1:0];
    lastc = {1'b0, sz} - {{CW{1'b0}}, 1'b1};
    if (ip >= lastc) begin
      r.p0 = sz - ONE_CW;
      r.p1 = sz - ONE_CW;
      fr   = '0;
    end else begin
      r.p0 = ip[CW-1:0];
      r.p1 = ip[CW-1:0] + ONE_CW;
    end
    r.w0 = UNITY - {1'b0, fr};
    r.w1 = {1'b0, fr};
    return r;
  endfunction

  // Product of two unity-scaled weights, renormalised and saturated.
  function automatic logic [FW-1:0] wmul(input logic [FW:0] a, input logic [FW:0] b);
    logic [2*FW+1:0] p;
    p = {{(FW+1){1'b0}}, a} * {{(FW+1){1'b0}}, b};
    return (|p[2*FW+1:2*FW]) ? {FW{1'b1}} : p[2*FW-1:FW];
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    src_w_q, src_h_q, dst_w_q, dst_h_q;
  logic [CNTW-1:0]  cnt_q;
  logic [CW-1:0]    rem_x_q, rem_y_q, rem_x_d, rem_y_d;
  logic [QW-1:0]    quo_x_q, quo_y_q, quo_x_d, quo_y_d;
  logic [CW:0]      trial_x, trial_y;
  logic [AW-1:0]    acc_x_q, acc_y_q, acc_x_d, acc_y_d;
  logic [AW-1:0]    start_x, start_y;
  logic [CW-1:0]    dx_q, dy_q, dx_d, dy_d;
  logic             load, xfer, line_end, last_xfer, size_zero;
  axis_t            ax, ay;

  logic [CW-1:0]    x0_q, x1_q, y0_q, y1_q;
  logic [FW-1:0]    w00_q, w01_q, w10_q, w11_q;
  logic             sof_q, eol_q;

  assign size_zero = (src_w_q == '0) || (src_h_q == '0) || (dst_w_q == '0) || (dst_h_q == '0);
  assign load      = (state_q == S_LOAD);
  assign xfer      = (state_q == S_RUN) && req_ready_i;
  assign line_end  = (dx_q == dst_w_q - ONE_CW);
  assign last_xfer = xfer && line_end && (dy_q == dst_h_q - ONE_CW);

  // Line/frame start accumulator value (quo_* holds the step after DIV).
`ifdef BILINEAR_HALF_PIXEL_EN
  localparam logic [AW-1:0] HALF_C = AW'(1) << (FW - 1);
  logic [AW-1:0] half_x, half_y;
  assign half_x  = {2'b00, quo_x_q[QW-1:1]};
  assign half_y  = {2'b00, quo_y_q[QW-1:1]};
  assign start_x = (half_x >= HALF_C) ? half_x - HALF_C : '0;
  assign start_y = (half_y >= HALF_C) ? half_y - HALF_C : '0;
`else
  assign start_x = '0;
  assign start_y = '0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; zero sizes are caught on the latched values in the first DIV cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_i) state_d = S_DIV;
      S_DIV: begin
        if (cnt_q == '0 && size_zero) state_d = S_DONE;
        else if (cnt_q == CNT_LAST)   state_d = S_LOAD;
      end
      S_LOAD: state_d = S_RUN;
      S_RUN:  if (last_xfer) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One restoring-division step per axis; quo_* shifts dividend out and quotient in.
  always_comb begin
    trial_x = {rem_x_q, quo_x_q[QW-1]};
    trial_y = {rem_y_q, quo_y_q[QW-1]};
    rem_x_d = trial_x[CW-1:0];
    rem_y_d = trial_y[CW-1:0];
    quo_x_d = {quo_x_q[QW-2:0], 1'b0};
    quo_y_d = {quo_y_q[QW-2:0], 1'b0};
    if (trial_x >= {1'b0, dst_w_q}) begin
      rem_x_d    = trial_x[CW-1:0] - dst_w_q;
      quo_x_d[0] = 1'b1;
    end
    if (trial_y >= {1'b0, dst_h_q}) begin
      rem_y_d    = trial_y[CW-1:0] - dst_h_q;
      quo_y_d[0] = 1'b1;
    end
  end

  // Size capture and divider iteration.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      src_w_q <= '0; src_h_q <= '0; dst_w_q <= '0; dst_h_q <= '0;
      cnt_q   <= '0;
      rem_x_q <= '0; rem_y_q <= '0; quo_x_q <= '0; quo_y_q <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      src_w_q <= src_width_i;  src_h_q <= src_height_i;
      dst_w_q <= dest_width_i; dst_h_q <= dest_height_i;
      cnt_q   <= '0;
      rem_x_q <= '0; rem_y_q <= '0;
      quo_x_q <= {src_width_i,  {FW{1'b0}}};
      quo_y_q <= {src_height_i, {FW{1'b0}}};
    end else if (state_q == S_DIV) begin
      cnt_q   <= cnt_q + CNT_ONE;
      rem_x_q <= rem_x_d; rem_y_q <= rem_y_d;
      quo_x_q <= quo_x_d; quo_y_q <= quo_y_d;
    end
  end

  // Raster walk: next accumulators/counters on load or handshake.
  always_comb begin
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    if (load) begin
      acc_x_d = start_x;
      acc_y_d = start_y;
      dx_d    = '0;
      dy_d    = '0;
    end else if (xfer) begin
      if (line_end) begin
        dx_d    = '0;
        acc_x_d = start_x;
        dy_d    = dy_q + ONE_CW;
        acc_y_d = acc_y_q + {1'b0, quo_y_q};
      end else begin
        dx_d    = dx_q + ONE_CW;
        acc_x_d = acc_x_q + {1'b0, quo_x_q};
      end
    end
    ax = map_axis(acc_x_d, src_w_q);
    ay = map_axis(acc_y_d, src_h_q);
  end

  // Walk state plus the registered request; only updates on load/handshake so a stall holds it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_x_q <= '0; acc_y_q <= '0; dx_q <= '0; dy_q <= '0;
      x0_q <= '0; x1_q <= '0; y0_q <= '0; y1_q <= '0;
      w00_q <= '0; w01_q <= '0; w10_q <= '0; w11_q <= '0;
      sof_q <= 1'b0; eol_q <= 1'b0;
    end else begin
      acc_x_q <= acc_x_d; acc_y_q <= acc_y_d;
      dx_q    <= dx_d;    dy_q    <= dy_d;
      if (load || xfer) begin
        x0_q  <= ax.p0; x1_q <= ax.p1;
        y0_q  <= ay.p0; y1_q <= ay.p1;
        w00_q <= wmul(ax.w0, ay.w0);
        w01_q <= wmul(ax.w1, ay.w0);
        w10_q <= wmul(ax.w0, ay.w1);
        w11_q <= wmul(ax.w1, ay.w1);
        sof_q <= (dx_d == '0) && (dy_d == '0);
        eol_q <= (dx_d == dst_w_q - ONE_CW);
      end
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign req_valid_o = (state_q == S_RUN);
  assign req_x0_o    = x0_q;
  assign req_x1_o    = x1_q;
  assign req_y0_o    = y0_q;
  assign req_y1_o    = y1_q;
  assign weight00_o  = w00_q;
  assign weight01_o  = w01_q;
  assign weight10_o  = w10_q;
  assign weight11_o  = w11_q;
  assign req_sof_o   = sof_q;
  assign req_eol_o   = eol_q;

endmodule

// File: tb/tb_bilinear_scale_ctrl.sv
// Self-checking bench for bilinear_scale_ctrl (top-left mapping build).
module tb_bilinear_scale_ctrl;
  localparam int F  = 12;
  localparam int CW = 16;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b0;
  logic [CW-1:0] sw_i = '0, sh_i = '0, dw_i = '0, dh_i = '0;
  logic busy, done, valid, sof, eol;
  logic [CW-1:0] x0, x1, y0, y1;
  logic [F-1:0]  w00, w01, w10, w11;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  bilinear_scale_ctrl #(.FIX_WIDTH(F), .COORD_WIDTH(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .src_width_i(sw_i), .src_height_i(sh_i), .dest_width_i(dw_i), .dest_height_i(dh_i),
    .busy_o(busy), .done_o(done), .req_valid_o(valid), .req_ready_i(ready),
    .req_x0_o(x0), .req_x1_o(x1), .req_y0_o(y0), .req_y1_o(y1),
    .weight00_o(w00), .weight01_o(w01), .weight10_o(w10), .weight11_o(w11),
    .req_sof_o(sof), .req_eol_o(eol)
  );

  typedef struct packed {
    logic [CW-1:0] x0, x1, y0, y1;
    logic [F-1:0]  w00, w01, w10, w11;
    logic          sof, eol;
  } req_t;

  typedef struct {
    int sw, sh, dw, dh;
    bit rnd, inj;
    int exp_n, last_x0, last_w00, p1_x1, p1_w01;
  } vec_t;

  function automatic req_t sample();
    return '{x0, x1, y0, y1, w00, w01, w10, w11, sof, eol};
  endfunction

  function automatic logic [F-1:0] wsat(input longint a, input longint b);
    longint p;
    p = (a * b) >> F;
    return (p > 4095) ? 12'hFFF : F'(p);
  endfunction

  // Reference: closed-form source position of pixel (dx,dy), then clamp and weights.
  function automatic req_t model(input int sw, input int sh, input int dw, input int dh,
                                 input int dx, input int dy);
    req_t r;
    longint ax, ay, ix, iy, fx, fy;
    ax = longint'(dx) * ((longint'(sw) << F) / dw);
    ay = longint'(dy) * ((longint'(sh) << F) / dh);
    ix = ax >> F; fx = ax % 4096;
    iy = ay >> F; fy = ay % 4096;
    if (ix >= sw - 1) begin r.x0 = CW'(sw - 1); r.x1 = CW'(sw - 1); fx = 0; end
    else begin r.x0 = CW'(ix); r.x1 = CW'(ix + 1); end
    if (iy >= sh - 1) begin r.y0 = CW'(sh - 1); r.y1 = CW'(sh - 1); fy = 0; end
    else begin r.y0 = CW'(iy); r.y1 = CW'(iy + 1); end
    r.w00 = wsat(4096 - fx, 4096 - fy);
    r.w01 = wsat(fx, 4096 - fy);
    r.w10 = wsat(4096 - fx, fy);
    r.w11 = wsat(fx, fy);
    r.sof = (dx == 0 && dy == 0);
    r.eol = (dx == dw - 1);
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_req(input string name, input req_t act, input req_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got x=%0d/%0d y=%0d/%0d w=%0d/%0d/%0d/%0d sof=%0b eol=%0b expected x=%0d/%0d y=%0d/%0d w=%0d/%0d/%0d/%0d sof=%0b eol=%0b",
               name, act.x0, act.x1, act.y0, act.y1, act.w00, act.w01, act.w10, act.w11, act.sof, act.eol,
               exp.x0, exp.x1, exp.y0, exp.y1, exp.w00, exp.w01, exp.w10, exp.w11, exp.sof, exp.eol);
    end
  endtask

  // Runs one frame starting at a negedge in IDLE; ends at the negedge of the IDLE cycle after done.
  task automatic run_frame(input int sw, input int sh, input int dw, input int dh,
                           input bit rnd, input bit inj,
                           output int n, output req_t p1, output req_t lastr);
    req_t q[$];
    req_t got, held, exp;
    int lat, inj_st;
    bit stall, was_last, done_seen;
    for (int y = 0; y < dh; y++)
      for (int x = 0; x < dw; x++) q.push_back(model(sw, sh, dw, dh, x, y));
    n = 0; p1 = '0; lastr = '0; inj_st = 0;
    sw_i = CW'(sw); sh_i = CW'(sh); dw_i = CW'(dw); dh_i = CW'(dh);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    check("busy_rise", busy, 1);
    while (!valid && lat < 100) begin @(negedge clk); lat++; end
    check("first_req_latency", lat, 30);
    stall = 1'b0; was_last = 1'b0; done_seen = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      got = sample();
      if (inj_st == 1) begin
        start = 1'b0; dw_i = CW'(dw); dh_i = CW'(dh); inj_st = 2;
      end
      if (done) begin
        done_seen = 1'b1;
        check("done_after_last_xfer", was_last, 1);
        check("valid_low_at_done", valid, 0);
      end else begin
        if (stall) begin
          check("stall_valid_held", valid, 1);
          check_req("stall_fields_held", got, held);
        end
        if (valid && ready) begin
          if (q.size() == 0) begin
            check("unexpected_extra_xfer", 1, 0);
            exp = '0;
          end else exp = q.pop_front();
          check_req("xfer", got, exp);
          n++;
          if (n == 2) p1 = got;
          lastr = got;
          was_last = (q.size() == 0);
          stall = 1'b0;
          if (inj && inj_st == 0 && n == 2) begin
            start = 1'b1; dw_i = 1; dh_i = 1; inj_st = 1;
          end
        end else begin
          was_last = 1'b0;
          stall = valid;
          held = got;
        end
      end
      @(negedge clk);
    end
    check("frame_done_seen", done_seen, 1);
    check("all_expected_sent", q.size(), 0);
    check("busy_low_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    start = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int n, wait_cnt;
    req_t p1, lastr;
    vecs[0] = '{4, 4, 4, 4, 1'b0, 1'b0, 16, 3, 4095, 2, 0};
    vecs[1] = '{2, 2, 4, 4, 1'b0, 1'b0, 16, 1, 4095, 1, 2048};
    vecs[2] = '{8, 6, 3, 2, 1'b1, 1'b1,  6, 5, 2732, 3, 2730};
    vecs[3] = '{4, 1, 8, 1, 1'b0, 1'b0,  8, 3, 4095, 1, 2048};
    vecs[4] = '{5, 3, 2, 4, 1'b1, 1'b0,  8, 2, 2048, 3, 2048};
    vecs[5] = '{1, 1, 3, 2, 1'b0, 1'b0,  6, 0, 4095, 0, 0};

    repeat (2) @(negedge clk);
    check("reset_ctl", {busy, done, valid}, 0);
    check_req("reset_fields", sample(), '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].sw, vecs[i].sh, vecs[i].dw, vecs[i].dh, vecs[i].rnd, vecs[i].inj, n, p1, lastr);
      check($sformatf("vec%0d_count", i), n, vecs[i].exp_n);
      check($sformatf("vec%0d_last_x0", i), lastr.x0, vecs[i].last_x0);
      check($sformatf("vec%0d_last_w00", i), lastr.w00, vecs[i].last_w00);
      check($sformatf("vec%0d_px1_x1", i), p1.x1, vecs[i].p1_x1);
      check($sformatf("vec%0d_px1_w01", i), p1.w01, vecs[i].p1_w01);
    end

    for (int i = 0; i < 4; i++) begin
      int rsw, rsh, rdw, rdh;
      rsw = $urandom_range(1, 9); rsh = $urandom_range(1, 9);
      rdw = $urandom_range(1, 9); rdh = $urandom_range(1, 9);
      run_frame(rsw, rsh, rdw, rdh, 1'b1, 1'b0, n, p1, lastr);
      check("rand_count", n, rdw * rdh);
    end

    // Zero destination width: done two cycles after start, no requests.
    sw_i = 4; sh_i = 4; dw_i = 0; dh_i = 4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_c1_busy", busy, 1);
    check("zero_c1_done", done, 0);
    check("zero_c1_valid", valid, 0);
    @(negedge clk);
    check("zero_c2_done", done, 1);
    check("zero_c2_valid", valid, 0);
    @(negedge clk);
    check("zero_idle_busy", busy, 0);

    // Async reset mid-RUN, then a clean frame.
    sw_i = 4; sh_i = 4; dw_i = 4; dh_i = 4; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; wait_cnt = 0;
    while (!valid && wait_cnt < 100) begin @(negedge clk); wait_cnt++; end
    check("rst_test_reached_run", valid, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async_ctl", {busy, done, valid}, 0);
    check_req("rst_async_fields", sample(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(4, 4, 4, 4, 1'b0, 1'b0, n, p1, lastr);
    check("post_rst_count", n, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
